vga_scanout: RTL

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_scanout_if.sv | 11 +
 rtl/vga_axis_counter.sv | 47 ++++
 rtl/vga_scanout.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared region encoding, default 640x480 timing constants and the test-bar helper
// used by the VGA scan-out block.
package vga_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FP     = 2'd1,
    SYNC   = 2'd2,
    BP     = 2'd3
  } region_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Eight equal-width bars across the visible line; divisor is a constant per build.
  function automatic logic [2:0] bar_index(input int h, input int h_active);
    return 3'((h * 8) / h_active);
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port: the scan-out engine is the master, the memory is the slave.
interface vga_scanout_if #(
  parameter int ADDR_W = 19
);
  logic [15:0]       q;
  logic [ADDR_W-1:0] addr;
  logic              rd_en;

  modport master (input q, output addr, output rd_en);
  modport slave  (output q, input addr, input rd_en);
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter advanced by i_en, plus decode of the
// current position into active / front porch / sync / back porch.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int A_LEN    = DEF_H_ACTIVE,
  parameter int FP_LEN   = DEF_H_FP,
  parameter int SYNC_LEN = DEF_H_SYNC,
  parameter int BP_LEN   = DEF_H_BP,
  localparam int TOTAL   = A_LEN + FP_LEN + SYNC_LEN + BP_LEN,
  localparam int CNT_W   = $clog2(TOTAL)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output region_t          o_region,
  output logic             o_wrap
);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last  = (r_count == CNT_W'(TOTAL - 1));
  assign o_wrap  = i_en && w_last;
  assign o_count = r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

  always_comb begin
    o_region = BP;
    if (r_count < CNT_W'(A_LEN)) begin
      o_region = ACTIVE;
    end else if (r_count < CNT_W'(A_LEN + FP_LEN)) begin
      o_region = FP;
    end else if (r_count < CNT_W'(A_LEN + FP_LEN + SYNC_LEN)) begin
      o_region = SYNC;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: raster timing, linear framebuffer read, two-stage output pipeline.
// Optional colour-bar generator enabled by macro VGA_TEST_PATTERN_EN.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int COLOR_W  = 3,
  parameter int ADDR_W   = 19
) (
  input  logic               clock,
  input  logic               reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               pattern,
`endif
  input  logic [15:0]        q,
  output logic [ADDR_W-1:0]  addr,
  output logic               rd_en,
  output logic               HS,
  output logic               VS,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               active,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v;
  region_t       w_h_region, w_v_region;
  logic          w_h_wrap, w_frame_wrap, w_visible;

  vga_axis_counter #(
    .A_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP)
  ) u_h_axis (
    .clock(clock), .reset(reset), .i_en(1'b1),
    .o_count(w_h), .o_region(w_h_region), .o_wrap(w_h_wrap)
  );

  vga_axis_counter #(
    .A_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP)
  ) u_v_axis (
    .clock(clock), .reset(reset), .i_en(w_h_wrap),
    .o_count(w_v), .o_region(w_v_region), .o_wrap(w_frame_wrap)
  );

  assign w_visible = (w_h_region == ACTIVE) && (w_v_region == ACTIVE);

`ifdef VGA_TEST_PATTERN_EN
  assign rd_en = w_visible && !pattern;
`else
  assign rd_en = w_visible;
`endif

  // The pointer tracks the raster even while bars suppress reads, so addr always equals v*H_ACTIVE+h.
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clock) begin
    if (reset || w_frame_wrap) begin
      r_addr <= '0;
    end else if (w_visible) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign addr = r_addr;

  logic r_p1_valid, r_p1_visible, r_p1_hsync, r_p1_vsync, r_p1_first;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_p1_valid   <= 1'b0;
      r_p1_visible <= 1'b0;
      r_p1_hsync   <= 1'b0;
      r_p1_vsync   <= 1'b0;
      r_p1_first   <= 1'b0;
    end else begin
      r_p1_valid   <= 1'b1;
      r_p1_visible <= w_visible;
      r_p1_hsync   <= (w_h_region == SYNC);
      r_p1_vsync   <= (w_v_region == SYNC);
      r_p1_first   <= (w_h == '0) && (w_v == '0);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic       r_p1_bar_en;
  logic [2:0] r_p1_bar;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_p1_bar_en <= 1'b0;
      r_p1_bar    <= 3'd0;
    end else begin
      r_p1_bar_en <= pattern;
      r_p1_bar    <= bar_index(int'(w_h), H_ACTIVE);
    end
  end
`endif

  logic [COLOR_W-1:0] w_r, w_g, w_b;
  logic               w_unused_q;

  assign w_unused_q = ^q[15:3*COLOR_W];

  always_comb begin
    w_r = q[3*COLOR_W-1:2*COLOR_W];
    w_g = q[2*COLOR_W-1:COLOR_W];
    w_b = q[COLOR_W-1:0];
`ifdef VGA_TEST_PATTERN_EN
    if (r_p1_bar_en) begin
      w_r = {COLOR_W{r_p1_bar[2]}};
      w_g = {COLOR_W{r_p1_bar[1]}};
      w_b = {COLOR_W{r_p1_bar[0]}};
    end
`endif
  end

  logic               r_hs, r_vs, r_active, r_frame_start;
  logic [COLOR_W-1:0] r_r, r_g, r_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hs          <= ~SYNC_POL;
      r_vs          <= ~SYNC_POL;
      r_active      <= 1'b0;
      r_frame_start <= 1'b0;
      r_r           <= '0;
      r_g           <= '0;
      r_b           <= '0;
    end else begin
      r_hs          <= (r_p1_valid && r_p1_hsync) ? SYNC_POL : ~SYNC_POL;
      r_vs          <= (r_p1_valid && r_p1_vsync) ? SYNC_POL : ~SYNC_POL;
      r_active      <= r_p1_valid && r_p1_visible;
      r_frame_start <= r_p1_valid && r_p1_first;
      r_r           <= (r_p1_valid && r_p1_visible) ? w_r : '0;
      r_g           <= (r_p1_valid && r_p1_visible) ? w_g : '0;
      r_b           <= (r_p1_valid && r_p1_visible) ? w_b : '0;
    end
  end

  assign HS          = r_hs;
  assign VS          = r_vs;
  assign active      = r_active;
  assign frame_start = r_frame_start;
  assign VGA_R       = r_r;
  assign VGA_G       = r_g;
  assign VGA_B       = r_b;

endmodule
